// File: rtl/pri_codec_pkg.sv
// Shared code definitions for the priority encoder / decoder tile pair.
package pri_codec_pkg;

    localparam logic [7:0] CODE_NONE = 8'hF0;
    localparam logic [7:0] CMD_ACCUM = 8'hA0;
    localparam logic [7:0] CMD_PULSE = 8'hA1;
    localparam logic [7:0] CMD_CLEAR = 8'hC0;

    typedef enum logic [1:0] {
        P_IDLE   = 2'd0,
        P_ACTIVE = 2'd1,
        ACCUM    = 2'd2
    } dec_state_t;

    // True when the code carries a winning index (0x00-0x0F).
    function automatic logic is_index(input logic [7:0] code);
        return (code[7:4] == 4'h0);
    endfunction

endpackage

// File: rtl/pri_sync2.sv
// Two-flop synchronizer with asynchronous reset to a chosen value.
module pri_sync2 #(
    parameter int         W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    // Two register stages; both start at RST_VAL so reset produces no edge downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/tt_um_priority_decoder.sv
// Receive-side priority decoder: turns edge events on the encoder code stream
// into a registered 16-bit one-hot pulse or accumulated request mask.
//
// Interface note: there is no handshake. ui_in is sampled every cycle through a
// 2-FF synchronizer; an event is any change of the synchronized code, and the
// mask output is valid every cycle straight from its register.
module tt_um_priority_decoder
    import pri_codec_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    logic [7:0]       s2;
    logic [7:0]       code_prev;
    logic             code_event;
    logic [15:0]      onehot;
    dec_state_t       state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [15:0]      mask, next_mask;

    // Observation point for checkers bound to the FSM.
    dec_state_t       dbg_state;
    assign dbg_state = state;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in};

    pri_sync2 #(.W(8), .RST_VAL(CODE_NONE)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in),
        .q     (s2)
    );

    assign code_event = (s2 != code_prev);
    assign onehot     = 16'(1) << s2[3:0];

    // Previous synchronized code, for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) code_prev <= CODE_NONE;
        else        code_prev <= s2;
    end

    // Next-state, counter and mask decode; commands override the per-state action.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_mask  = mask;
        case (state)
            P_IDLE: begin
                if (code_event && is_index(s2)) begin
                    next_mask  = onehot;
                    next_cnt   = CNT_RELOAD;
                    next_state = P_ACTIVE;
                end
            end
            P_ACTIVE: begin
                if (code_event && is_index(s2)) begin
                    next_mask = onehot;
                    next_cnt  = CNT_RELOAD;
                end else if (cnt != '0) begin
                    next_cnt = cnt - 1'b1;
                end else begin
                    next_mask  = '0;
                    next_state = P_IDLE;
                end
            end
            ACCUM: begin
                if (code_event && is_index(s2)) next_mask = mask | onehot;
            end
            default: begin
                next_state = P_IDLE;
                next_mask  = '0;
                next_cnt   = '0;
            end
        endcase
        if (code_event) begin
            case (s2)
                CMD_CLEAR: begin
                    next_mask  = '0;
                    next_cnt   = '0;
                    next_state = (state == ACCUM) ? ACCUM : P_IDLE;
                end
                CMD_ACCUM: begin
                    next_mask  = '0;
                    next_cnt   = '0;
                    next_state = ACCUM;
                end
                CMD_PULSE: begin
                    next_mask  = '0;
                    next_cnt   = '0;
                    next_state = P_IDLE;
                end
                default: ;
            endcase
        end
    end

    // State, counter and mask registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= P_IDLE;
            cnt   <= '0;
            mask  <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            mask  <= next_mask;
        end
    end

    assign uo_out  = mask[15:8];
    assign uio_out = mask[7:0];
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_priority_decoder.sv
// Directed-vector bench for tt_um_priority_decoder with a scoreboard queue.
module tb_tt_um_priority_decoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    logic [15:0] exp_q[$];
    int          id_q[$];
    int          total = 0;
    int          bad   = 0;
    int          step_no = 0;

    tt_um_priority_decoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply code before the next rising edge; exp is the mask seen after it.
    task automatic drive(input logic [7:0] code, input logic [15:0] exp);
        @(negedge clk);
        ui_in = code;
        exp_q.push_back(exp);
        id_q.push_back(step_no);
        step_no++;
    endtask

    task automatic drive_n(input logic [7:0] code, input logic [15:0] exp, input int n);
        for (int i = 0; i < n; i++) drive(code, exp);
    endtask

    task automatic check_now(input string name, input logic [15:0] exp);
        total++;
        if ({uo_out, uio_out} !== exp) begin
            bad++;
            $display("FAIL %s: mask=%h expected=%h", name, {uo_out, uio_out}, exp);
        end
    endtask

    // Monitor: output is valid every cycle; pop one expectation per edge.
    initial begin
        logic [15:0] e;
        int          id;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                total++;
                if ({uo_out, uio_out} !== e || uio_oe !== 8'hFF) begin
                    bad++;
                    $display("FAIL step%0d: mask=%h oe=%h expected mask=%h oe=ff",
                             id, {uo_out, uio_out}, uio_oe, e);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hF0;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        check_now("reset_mask", 16'h0000);
        rst_n = 1'b1;

        // 1. Idle after reset
        drive_n(8'hF0, 16'h0000, 10);

        // 2. Single pulse, held code
        drive_n(8'h05, 16'h0000, 2);
        drive_n(8'h05, 16'h0020, 4);
        drive_n(8'h05, 16'h0000, 2);
        drive_n(8'hF0, 16'h0000, 3);

        // 3. Retrigger two cycles after the first index
        drive_n(8'h05, 16'h0000, 2);
        drive_n(8'h0C, 16'h0020, 2);
        drive_n(8'h0C, 16'h1000, 4);
        drive_n(8'h0C, 16'h0000, 1);
        drive_n(8'hF0, 16'h0000, 3);

        // 4. Accumulate mode, repeated index, clear, back to pulse mode
        drive_n(8'hA0, 16'h0000, 2);
        drive_n(8'h03, 16'h0000, 2);
        drive_n(8'hF0, 16'h0008, 2);
        drive_n(8'h0F, 16'h0008, 2);
        drive_n(8'hF0, 16'h8008, 2);
        drive_n(8'h03, 16'h8008, 2);
        drive_n(8'h55, 16'h8008, 2);
        drive_n(8'hC0, 16'h8008, 2);
        drive_n(8'hF0, 16'h0000, 3);
        drive_n(8'hA1, 16'h0000, 2);
        drive_n(8'hF0, 16'h0000, 3);

        // 5. Long-held index gives one pulse; unknown code is ignored
        drive_n(8'h07, 16'h0000, 2);
        drive_n(8'h07, 16'h0080, 4);
        drive_n(8'h07, 16'h0000, 14);
        drive_n(8'h55, 16'h0000, 4);
        drive_n(8'hF0, 16'h0000, 3);

        // 6. Asynchronous reset mid-pulse
        drive_n(8'h09, 16'h0000, 2);
        drive_n(8'h09, 16'h0200, 2);
        @(posedge clk);
        #3;
        check_now("pre_reset_pulse", 16'h0200);
        ui_in = 8'hF0;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_drop", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive_n(8'hF0, 16'h0000, 2);
        drive_n(8'h02, 16'h0000, 2);
        drive_n(8'h02, 16'h0004, 4);
        drive_n(8'h02, 16'h0000, 2);
        drive_n(8'hF0, 16'h0000, 2);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
